uart_receiver_fsm: RTL and testbench
====================================

UART_RECEIVER_FSM -- requirements
Module: uart_receiver_fsm

Interface
REQ-001 Parameter CLOCKSPEED, default 50000000, SHALL be the clk frequency in Hz.
REQ-002 Parameter BAUDRATE, default 9600, SHALL be the serial bit rate in baud.
REQ-003 Derived constant BAUD_CLOCK = CLOCKSPEED/(BAUDRATE*16), integer division, SHALL be the clk cycles per oversample tick (325 at defaults).
REQ-004 clk  input  1  SHALL be the single clock; all logic samples on the rising edge.
REQ-005 rst  input  1  SHALL be a synchronous, active-high reset, sampled on the rising clk edge.
REQ-006 rx  input  1  SHALL be the asynchronous UART serial line: idle high, 8N1, LSB first.
REQ-007 dout  output  8  SHALL carry the last correctly received data byte.
REQ-008 valid  output  1  SHALL pulse high for exactly one clk cycle when dout is updated.
REQ-009 frame_err  output  1  SHALL pulse high for exactly one clk cycle when a stop bit samples low.
REQ-010 busy  output  1  SHALL be high in every state except IDLE.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer (rx_s), reset value 1; all decisions use rx_s only.
REQ-012 Tick divider: counter 0..BAUD_CLOCK-1; one-cycle tick when counter = BAUD_CLOCK-1, then wrap to 0; free-running, cleared only by rst.
REQ-013 A 4-bit oversample counter (os_cnt) SHALL advance on ticks only and wrap 15->0.
REQ-014 States SHALL be IDLE, START, DATA, STOP.
REQ-015 IDLE: armed flag set on any tick with rx_s=1; on a tick with rx_s=0 and armed=1 -> START, os_cnt=0.
REQ-016 START: on the tick where os_cnt reaches 7 (mid start bit), rx_s=0 -> DATA with os_cnt=0 and bit_cnt=0; rx_s=1 -> IDLE (glitch rejected, no outputs).
REQ-017 DATA: on each tick where os_cnt reaches 15 (mid bit), shift rx_s into MSB of shift register (right shift, LSB first); bit_cnt 3-bit increments; after 8th sample (bit_cnt=7) -> STOP, os_cnt=0.
REQ-018 STOP: on tick where os_cnt reaches 15, rx_s=1 -> dout=shift register, valid=1 for one cycle, -> IDLE with armed=1.
REQ-019 STOP with rx_s=0 -> frame_err=1 for one cycle, dout unchanged, valid stays 0, -> IDLE with armed=0 (re-arms only after line returns high; held-low break yields exactly one frame_err).
REQ-020 Latency: valid asserts in the clk cycle after the mid-stop-bit sample tick, about 9.5 bit times after the start-bit falling edge, plus 2 synchronizer cycles.
REQ-021 valid and frame_err SHALL never be high in the same cycle.
REQ-022 Back-to-back frames: a start edge on the first tick after STOP completes SHALL be accepted without loss.
REQ-023 rx activity in START/DATA/STOP other than at sample ticks SHALL be ignored; no mid-frame resynchronization.

Reset
REQ-024 rst=1 SHALL force: state=IDLE, armed=0, tick counter=0, os_cnt=0, bit_cnt=0, shift register=0, synchronizer flops=1, dout=8'h00, valid=0, frame_err=0, busy=0.
REQ-025 rst asserted mid-frame SHALL abort the frame with no valid or frame_err pulse; reception resumes only after line-high re-arm.

Verification (CLOCKSPEED=1600, BAUDRATE=10 -> BAUD_CLOCK=10, 160 clk/bit)
REQ-026 Idle high, then frame 0x55, stop=1 -> one valid pulse, dout=8'h55, frame_err never high, busy low afterward.
REQ-027 Back-to-back 0xA5 then 0x3C, no idle gap -> two valid pulses 1600 clk apart, dout=8'hA5 then 8'h3C.
REQ-028 rx low pulse of 40 clk (shorter than half a bit) -> state returns to IDLE, no valid, no frame_err.
REQ-029 Frame 0xFF with stop bit driven 0, line held low 3000 clk -> exactly one frame_err pulse, dout unchanged, no valid; next good frame 0x81 received after line goes high.
REQ-030 rst pulsed for 1 clk during bit 4 of a 0x96 frame -> all outputs at reset values, no pulse; subsequent 0x12 frame received correctly.

Source files
------------

// File: rtl/uart_receiver_fsm_if.sv
// Serial-side bundle of the UART receiver: the incoming line plus the
// received-byte result and status strobes.
interface uart_receiver_fsm_if;
    logic       rx;
    logic [7:0] dout;
    logic       valid;
    logic       frame_err;
    logic       busy;

    // Line driver / byte consumer side
    modport master (
        output rx,
        input  dout,
        input  valid,
        input  frame_err,
        input  busy
    );

    // Receiver side
    modport slave (
        input  rx,
        output dout,
        output valid,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/uart_receiver_fsm.sv
// 8N1 UART receiver with 16x oversampling. The start bit is confirmed at its
// midpoint, then every following bit is sampled once per 16 oversample ticks,
// which lands each sample near the middle of its bit cell.
module uart_receiver_fsm #(
    parameter int CLOCKSPEED = 50000000,
    parameter int BAUDRATE   = 9600
) (
    input  logic                clk,
    input  logic                rst,
    uart_receiver_fsm_if.slave  bus
);

    localparam int BAUD_CLOCK = CLOCKSPEED / (BAUDRATE * 16);
    localparam int TICK_W     = (BAUD_CLOCK > 1) ? $clog2(BAUD_CLOCK) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BAUD_CLOCK - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic              r_rxMeta;
    logic              r_rxSync;
    logic [TICK_W-1:0] r_tickCnt;
    logic              w_tick;

    state_t            r_state;
    state_t            w_nextState;
    logic [3:0]        r_osCnt;
    logic [3:0]        w_osCntNext;
    logic [2:0]        r_bitCnt;
    logic [2:0]        w_bitCntNext;
    logic [7:0]        r_shiftReg;
    logic [7:0]        w_shiftRegNext;
    logic              r_armed;
    logic              w_armedNext;
    logic [7:0]        r_dout;
    logic [7:0]        w_doutNext;
    logic              r_valid;
    logic              w_validNext;
    logic              r_frameErr;
    logic              w_frameErrNext;

    // Two-flop synchronizer for the asynchronous line; resets to idle-high
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rxMeta <= 1'b1;
            r_rxSync <= 1'b1;
        end else begin
            r_rxMeta <= bus.rx;
            r_rxSync <= r_rxMeta;
        end
    end

    // Free-running divider producing one oversample tick every BAUD_CLOCK cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tickCnt <= '0;
        end else if (r_tickCnt == TICK_LAST) begin
            r_tickCnt <= '0;
        end else begin
            r_tickCnt <= r_tickCnt + TICK_W'(1);
        end
    end

    assign w_tick = (r_tickCnt == TICK_LAST);

    // State and datapath registers, loaded from the next-state logic below
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_osCnt    <= 4'd0;
            r_bitCnt   <= 3'd0;
            r_shiftReg <= 8'h00;
            r_armed    <= 1'b0;
            r_dout     <= 8'h00;
            r_valid    <= 1'b0;
            r_frameErr <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_osCnt    <= w_osCntNext;
            r_bitCnt   <= w_bitCntNext;
            r_shiftReg <= w_shiftRegNext;
            r_armed    <= w_armedNext;
            r_dout     <= w_doutNext;
            r_valid    <= w_validNext;
            r_frameErr <= w_frameErrNext;
        end
    end

    // Next-state and datapath decisions; every sample is taken on a tick only
    always_comb begin
        w_nextState    = r_state;
        w_osCntNext    = w_tick ? (r_osCnt + 4'd1) : r_osCnt;
        w_bitCntNext   = r_bitCnt;
        w_shiftRegNext = r_shiftReg;
        w_armedNext    = r_armed;
        w_doutNext     = r_dout;
        w_validNext    = 1'b0;
        w_frameErrNext = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_tick) begin
                    if (r_rxSync) begin
                        w_armedNext = 1'b1;
                    end else if (r_armed) begin
                        w_nextState = START;
                        w_osCntNext = 4'd0;
                    end
                end
            end

            START: begin
                if (w_tick && (r_osCnt == 4'd7)) begin
                    if (!r_rxSync) begin
                        w_nextState  = DATA;
                        w_osCntNext  = 4'd0;
                        w_bitCntNext = 3'd0;
                    end else begin
                        w_nextState = IDLE;
                    end
                end
            end

            DATA: begin
                if (w_tick && (r_osCnt == 4'd15)) begin
                    w_shiftRegNext = {r_rxSync, r_shiftReg[7:1]};
                    w_bitCntNext   = r_bitCnt + 3'd1;
                    if (r_bitCnt == 3'd7) begin
                        w_nextState = STOP;
                        w_osCntNext = 4'd0;
                    end
                end
            end

            STOP: begin
                if (w_tick && (r_osCnt == 4'd15)) begin
                    w_nextState = IDLE;
                    if (r_rxSync) begin
                        w_doutNext  = r_shiftReg;
                        w_validNext = 1'b1;
                        w_armedNext = 1'b1;
                    end else begin
                        w_frameErrNext = 1'b1;
                        w_armedNext    = 1'b0;
                    end
                end
            end

            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    assign bus.dout      = r_dout;
    assign bus.valid     = r_valid;
    assign bus.frame_err = r_frameErr;
    assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_receiver_fsm.sv
// Directed bench for uart_receiver_fsm at 1600 Hz / 10 baud (160 clk per bit).
module tb_uart_receiver_fsm;

    localparam int BIT_CLK = 160;

    logic clk;
    logic rst;

    uart_receiver_fsm_if bus ();

    uart_receiver_fsm #(
        .CLOCKSPEED (1600),
        .BAUDRATE   (10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    int cycleCount  = 0;
    int validCount  = 0;
    int ferrCount   = 0;
    int bothHigh    = 0;
    int longPulse   = 0;
    logic prevValid = 1'b0;
    logic prevFerr  = 1'b0;
    logic [7:0] validData [0:15];
    int         validCycle [0:15];

    // 100 MHz-style free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter for latency and spacing measurements
    always @(posedge clk) begin
        cycleCount <= cycleCount + 1;
    end

    // Output monitor sampled on the falling edge, away from DUT updates
    always @(negedge clk) begin
        if (bus.valid === 1'b1) begin
            if (validCount < 16) begin
                validData[validCount]  = bus.dout;
                validCycle[validCount] = cycleCount;
            end
            validCount = validCount + 1;
        end
        if (bus.frame_err === 1'b1) ferrCount = ferrCount + 1;
        if ((bus.valid === 1'b1) && (bus.frame_err === 1'b1)) bothHigh = bothHigh + 1;
        if (((bus.valid === 1'b1) && prevValid) || ((bus.frame_err === 1'b1) && prevFerr))
            longPulse = longPulse + 1;
        prevValid = (bus.valid === 1'b1);
        prevFerr  = (bus.frame_err === 1'b1);
    end

    // Hard stop in case the sequence never completes
    initial begin
        repeat (60000) @(posedge clk);
        $display("[TB] FAIL timeout: observed no completion, expected finish within 60000 cycles");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors = vectors + 1;
        assert (observed === expected) else begin
            miscompares = miscompares + 1;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic holdLine(input logic value, input int cycles);
        bus.rx = value;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic stopVal);
        holdLine(1'b0, BIT_CLK);
        for (int i = 0; i < 8; i++) holdLine(data[i], BIT_CLK);
        holdLine(stopVal, BIT_CLK);
    endtask

    initial begin
        int baseV;
        int baseF;
        int startCycle;
        int lat;
        logic [7:0] partial;

        rst    = 1'b1;
        bus.rx = 1'b1;
        repeat (5) @(negedge clk);

        // Reset state
        checkOutput("rst_dout",      32'(bus.dout),      32'h00);
        checkOutput("rst_valid",     32'(bus.valid),     32'h0);
        checkOutput("rst_frame_err", 32'(bus.frame_err), 32'h0);
        checkOutput("rst_busy",      32'(bus.busy),      32'h0);
        rst = 1'b0;
        holdLine(1'b1, 500);

        // Single good frame 0x55
        $display("[TB] frame 0x55");
        baseV = validCount; baseF = ferrCount;
        startCycle = cycleCount;
        applyStimulus(8'h55, 1'b1);
        holdLine(1'b1, 200);
        checkOutput("p1_valid_count", 32'(validCount - baseV), 32'd1);
        checkOutput("p1_dout",        32'(validData[baseV]),   32'h55);
        checkOutput("p1_ferr_count",  32'(ferrCount - baseF),  32'd0);
        checkOutput("p1_busy_after",  32'(bus.busy),           32'h0);
        lat = validCycle[baseV] - startCycle;
        checkOutput("p1_latency_window", 32'((lat >= 1518) && (lat <= 1540)), 32'd1);

        // Back-to-back 0xA5, 0x3C with no idle gap
        $display("[TB] back-to-back 0xA5 0x3C");
        baseV = validCount; baseF = ferrCount;
        applyStimulus(8'hA5, 1'b1);
        applyStimulus(8'h3C, 1'b1);
        holdLine(1'b1, 300);
        checkOutput("p2_valid_count", 32'(validCount - baseV), 32'd2);
        checkOutput("p2_dout_first",  32'(validData[baseV]),   32'hA5);
        checkOutput("p2_dout_second", 32'(validData[baseV+1]), 32'h3C);
        checkOutput("p2_spacing",     32'(validCycle[baseV+1] - validCycle[baseV]), 32'd1600);
        checkOutput("p2_ferr_count",  32'(ferrCount - baseF),  32'd0);

        // 40-clk low glitch is rejected at the start-bit midpoint
        $display("[TB] 40 clk glitch");
        baseV = validCount; baseF = ferrCount;
        holdLine(1'b0, 30);
        checkOutput("p3_busy_during", 32'(bus.busy), 32'h1);
        holdLine(1'b0, 10);
        holdLine(1'b1, 300);
        checkOutput("p3_valid_count", 32'(validCount - baseV), 32'd0);
        checkOutput("p3_ferr_count",  32'(ferrCount - baseF),  32'd0);
        checkOutput("p3_busy_after",  32'(bus.busy),           32'h0);
        checkOutput("p3_dout_kept",   32'(bus.dout),           32'h3C);

        // 0xFF with low stop bit, then a long break
        $display("[TB] framing error with held break");
        baseV = validCount; baseF = ferrCount;
        applyStimulus(8'hFF, 1'b0);
        holdLine(1'b0, 3000);
        holdLine(1'b1, 300);
        checkOutput("p4_ferr_count",  32'(ferrCount - baseF),  32'd1);
        checkOutput("p4_valid_count", 32'(validCount - baseV), 32'd0);
        checkOutput("p4_dout_kept",   32'(bus.dout),           32'h3C);
        baseV = validCount; baseF = ferrCount;
        applyStimulus(8'h81, 1'b1);
        holdLine(1'b1, 200);
        checkOutput("p4_next_valid_count", 32'(validCount - baseV), 32'd1);
        checkOutput("p4_next_dout",        32'(validData[baseV]),   32'h81);
        checkOutput("p4_next_ferr_count",  32'(ferrCount - baseF),  32'd0);

        // Reset pulse in the middle of bit 4 of a 0x96 frame
        $display("[TB] reset mid-frame");
        baseV = validCount; baseF = ferrCount;
        partial = 8'h96;
        holdLine(1'b0, BIT_CLK);
        for (int i = 0; i < 4; i++) holdLine(partial[i], BIT_CLK);
        holdLine(partial[4], 80);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("p5_rst_dout",      32'(bus.dout),      32'h00);
        checkOutput("p5_rst_valid",     32'(bus.valid),     32'h0);
        checkOutput("p5_rst_frame_err", 32'(bus.frame_err), 32'h0);
        checkOutput("p5_rst_busy",      32'(bus.busy),      32'h0);
        holdLine(partial[4], 79);
        for (int i = 5; i < 8; i++) holdLine(partial[i], BIT_CLK);
        holdLine(1'b1, BIT_CLK);
        checkOutput("p5_no_valid", 32'(validCount - baseV), 32'd0);
        checkOutput("p5_no_ferr",  32'(ferrCount - baseF),  32'd0);
        holdLine(1'b1, 2000);
        baseV = validCount; baseF = ferrCount;
        applyStimulus(8'h12, 1'b1);
        holdLine(1'b1, 300);
        checkOutput("p5_next_valid_count", 32'(validCount - baseV), 32'd1);
        checkOutput("p5_next_dout",        32'(validData[baseV]),   32'h12);
        checkOutput("p5_next_ferr_count",  32'(ferrCount - baseF),  32'd0);

        // Whole-run pulse properties
        checkOutput("valid_and_ferr_overlap", 32'(bothHigh),  32'd0);
        checkOutput("pulse_longer_than_one",  32'(longPulse), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
